// File: rtl/mdu_seq.sv
// -----------------------------------------------------------------------------
// mdu_seq -- iterative multiply/divide unit owning the HI/LO registers.
//
// Executes MULT/MULTU/DIV/DIVU one radix-2 step per cycle on unsigned
// magnitudes, then applies the result signs in a single FIX cycle.
// Total latency from the start cycle to the done pulse is WIDTH+2 cycles.
//
// Ports:
//   clk    : clock, all state updates on the rising edge
//   rst_n  : asynchronous active-low reset
//   start  : operation request, sampled only while idle
//   op     : 00 MULT, 01 MULTU, 10 DIV, 11 DIVU (sampled with start)
//   a, b   : multiplicand/dividend and multiplier/divisor
//   hi_we  : MTHI write enable (honoured only while not busy)
//   lo_we  : MTLO write enable (honoured only while not busy)
//   wdata  : MTHI/MTLO write data
//   busy   : operation in progress
//   done   : one-cycle pulse, hi/lo hold the new result in that cycle
//   hi, lo : HI/LO registers (product high/low, remainder/quotient)
// -----------------------------------------------------------------------------
module mdu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             is_div;
  logic             neg_res;
  logic             neg_rem;
  logic             div_zero;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] mcand;

  // Operand magnitudes; unsigned ops (op[0]=1) pass the raw values through.
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  assign a_neg = ~op[0] & a[WIDTH-1];
  assign b_neg = ~op[0] & b[WIDTH-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  // Multiply step: {acc_hi,acc_lo} holds partial product and the remaining
  // multiplier bits; add mcand into the top half when the LSB is set, then
  // shift the whole accumulator right by one (carry enters at the top).
  logic [WIDTH:0]   mul_sum;
  assign mul_sum = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? mcand : {WIDTH{1'b0}})};

  // Restoring divide step: acc_hi is the partial remainder, acc_lo shifts the
  // dividend out at the top and the quotient bits in at the bottom. The
  // shifted remainder needs WIDTH+1 bits; after a successful subtract the
  // result is below the divisor, so WIDTH-bit arithmetic is exact.
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem;
  assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, mcand};
  assign div_rem   = div_ge ? (div_shift[WIDTH-1:0] - mcand) : div_shift[WIDTH-1:0];

  // Sign fix-up. Divide by zero forces the quotient to all ones; the
  // remainder path already yields the original dividend in that case.
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quo_s;
  logic [WIDTH-1:0]   rem_s;
  assign prod   = {acc_hi, acc_lo};
  assign prod_s = neg_res ? -prod : prod;
  assign quo_s  = div_zero ? {WIDTH{1'b1}} : (neg_res ? -acc_lo : acc_lo);
  assign rem_s  = neg_rem ? -acc_hi : acc_hi;

  // Control FSM and datapath registers. busy is high exactly in CALC/FIX,
  // so HI/LO writes from the pipeline are only accepted in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      mcand    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start) begin
            is_div   <= op[1];
            neg_res  <= a_neg ^ b_neg;
            neg_rem  <= op[1] & a_neg;
            div_zero <= op[1] & (b == '0);
            acc_hi   <= '0;
            acc_lo   <= op[1] ? a_mag : b_mag;
            mcand    <= op[1] ? b_mag : a_mag;
            cnt      <= '0;
            busy     <= 1'b1;
            state    <= CALC;
          end
        end
        CALC: begin
          if (is_div) begin
            acc_hi <= div_rem;
            acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
          end else begin
            acc_hi <= mul_sum[WIDTH:1];
            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
          end
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          if (is_div) begin
            hi <= rem_s;
            lo <= quo_s;
          end else begin
            hi <= prod_s[2*WIDTH-1:WIDTH];
            lo <= prod_s[WIDTH-1:0];
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
